ysyx_22051013_trap_seq: RTL and testbench

//  Sequencer that owns the CSR file's control port (csr_ctl/csr_addr/write data/mcause).

---
 rtl/ysyx_22051013_trap_seq_if.sv | 36 +++
 rtl/ysyx_22051013_trap_seq.sv | 158 +++++++++++++++
 tb/tb_ysyx_22051013_trap_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22051013_trap_seq_if.sv
// Bundles the EXU request/response, interrupt inputs and CSR-file control port
// of the trap sequencer; the sequencer connects through the slave modport.
interface ysyx_22051013_trap_seq_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_src;
  logic [XLEN-1:0] req_pc;
  logic            irq_timer;
  logic            irq_mie;
  logic [3:0]      csr_ctl;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] mcause_value;
  logic [XLEN-1:0] csr_rdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic            busy;

  modport slave (
    input  req_valid, req_op, req_addr, req_src, req_pc, irq_timer, irq_mie, csr_rdata,
    output req_ready, csr_ctl, csr_addr, csr_wdata, mcause_value,
           rsp_valid, rsp_rdata, redir_valid, redir_pc, busy
  );

  modport master (
    output req_valid, req_op, req_addr, req_src, req_pc, irq_timer, irq_mie, csr_rdata,
    input  req_ready, csr_ctl, csr_addr, csr_wdata, mcause_value,
           rsp_valid, rsp_rdata, redir_valid, redir_pc, busy
  );
endinterface

// File: rtl/ysyx_22051013_trap_seq.sv
// Serialises CSR read-modify-write, ecall, mret and timer interrupts into
// CSR-file cycles and returns the old CSR value or a PC redirect.
module ysyx_22051013_trap_seq #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] ECALL_CS = 64'd11,
  parameter logic [XLEN-1:0] TIMER_CS = 64'h8000_0000_0000_0007
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_22051013_trap_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CSR_RD = 3'd1,
    CSR_WR = 3'd2,
    TRAP   = 3'd3,
    RET    = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t          state_reg, state_next;
  logic [2:0]      op_reg;
  logic [11:0]     addr_reg;
  logic [XLEN-1:0] src_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] cause_reg;
  logic [XLEN-1:0] old_reg;
  logic [XLEN-1:0] target_reg;
  logic            redir_reg;
  logic            csr_op_reg;

  logic            irq_take;
  logic [XLEN-1:0] new_val;
  logic            wr_skip;

  assign irq_take = bus.irq_timer & bus.irq_mie;

  always_comb begin
    case (op_reg)
      3'd0:    new_val = src_reg;
      3'd1:    new_val = old_reg | src_reg;
      default: new_val = old_reg & ~src_reg;
    endcase
  end

  // Set/clear with a zero mask must not touch the CSR (read-only access).
  assign wr_skip = (op_reg != 3'd0) && (src_reg == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (irq_take) begin
          state_next = TRAP;
        end else if (bus.req_valid) begin
          case (bus.req_op)
            3'd0, 3'd1, 3'd2: state_next = CSR_RD;
            3'd3:             state_next = TRAP;
            3'd4:             state_next = RET;
            default:          state_next = RESP;
          endcase
        end
      end
      CSR_RD:  state_next = CSR_WR;
      CSR_WR:  state_next = RESP;
      TRAP:    state_next = RESP;
      RET:     state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_reg     <= '0;
      addr_reg   <= '0;
      src_reg    <= '0;
      pc_reg     <= '0;
      cause_reg  <= '0;
      old_reg    <= '0;
      target_reg <= '0;
      redir_reg  <= 1'b0;
      csr_op_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (irq_take) begin
            pc_reg     <= bus.req_pc;
            cause_reg  <= TIMER_CS;
            redir_reg  <= 1'b1;
            csr_op_reg <= 1'b0;
          end else if (bus.req_valid) begin
            op_reg     <= bus.req_op;
            addr_reg   <= bus.req_addr;
            src_reg    <= bus.req_src;
            pc_reg     <= bus.req_pc;
            cause_reg  <= ECALL_CS;
            redir_reg  <= (bus.req_op == 3'd3) || (bus.req_op == 3'd4);
            csr_op_reg <= (bus.req_op < 3'd3);
          end
        end
        CSR_RD: old_reg <= bus.csr_rdata;
        // mtvec is used in direct mode only: the mode bits are dropped.
        TRAP:   target_reg <= {bus.csr_rdata[XLEN-1:2], 2'b00};
        RET:    target_reg <= bus.csr_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready    = 1'b0;
    bus.busy         = (state_reg != IDLE);
    bus.csr_ctl      = 4'b0000;
    bus.csr_addr     = '0;
    bus.csr_wdata    = '0;
    bus.mcause_value = '0;
    bus.rsp_valid    = 1'b0;
    bus.rsp_rdata    = '0;
    bus.redir_valid  = 1'b0;
    bus.redir_pc     = '0;
    case (state_reg)
      IDLE: bus.req_ready = ~irq_take;
      CSR_RD: begin
        bus.csr_ctl  = 4'b0100;
        bus.csr_addr = addr_reg;
      end
      CSR_WR: begin
        bus.csr_ctl   = wr_skip ? 4'b0000 : 4'b1000;
        bus.csr_addr  = addr_reg;
        bus.csr_wdata = new_val;
      end
      TRAP: begin
        bus.csr_ctl      = 4'b0010;
        bus.csr_wdata    = pc_reg;
        bus.mcause_value = cause_reg;
      end
      RET: bus.csr_ctl = 4'b0001;
      RESP: begin
        bus.rsp_valid   = 1'b1;
        bus.rsp_rdata   = csr_op_reg ? old_reg : '0;
        bus.redir_valid = redir_reg;
        bus.redir_pc    = redir_reg ? target_reg : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22051013_trap_seq.sv
// Drives the trap sequencer against a behavioural CSR file and checks each
// transaction's result, latency and CSR side effects with a transaction-level model.
module tb_ysyx_22051013_trap_seq;
  localparam logic [63:0] ECALL_CS = 64'd11;
  localparam logic [63:0] TIMER_CS = 64'h8000_0000_0000_0007;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_22051013_trap_seq_if #(.XLEN(64)) bus ();

  ysyx_22051013_trap_seq #(.XLEN(64), .ECALL_CS(ECALL_CS), .TIMER_CS(TIMER_CS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Behavioural CSR file: combinational read, writes on the clock edge.
  logic [63:0] csr_mem [0:4095];
  int wr_count = 0;

  always_comb begin
    case (bus.csr_ctl)
      4'b0100: bus.csr_rdata = csr_mem[bus.csr_addr];
      4'b0010: bus.csr_rdata = csr_mem[12'h305];
      4'b0001: bus.csr_rdata = csr_mem[12'h341];
      default: bus.csr_rdata = 64'd0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.csr_ctl[3]) begin
      csr_mem[bus.csr_addr] <= bus.csr_wdata;
      wr_count <= wr_count + 1;
    end
    if (bus.csr_ctl[1]) begin
      csr_mem[12'h341] <= bus.csr_wdata;
      csr_mem[12'h342] <= bus.mcause_value;
    end
  end

  always @(negedge clk) begin
    if (rst) chk("ctl_onehot", 64'($countones(bus.csr_ctl) <= 1), 64'd1);
  end

  logic [3:0]  tr_ctl    [0:8];
  logic [63:0] tr_wdata  [0:8];
  logic [63:0] tr_mcause [0:8];

  task automatic wait_rsp(input bit drop, output int lat);
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (drop) bus.req_valid = 1'b0;
      #1;
      tr_ctl[n]    = bus.csr_ctl;
      tr_wdata[n]  = bus.csr_wdata;
      tr_mcause[n] = bus.mcause_value;
      if (bus.rsp_valid) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [11:0] addr,
                        input logic [63:0] src, input logic [63:0] pc);
    logic [63:0] old_v, new_v, exp_rdata, exp_pc;
    int exp_lat, exp_wr, wr0, lat, k;
    bit exp_redir, skip;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_src   = src;
    bus.req_pc    = pc;
    #1;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk); #1; k++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    old_v = csr_mem[addr];
    exp_rdata = 64'd0; exp_pc = 64'd0; exp_redir = 1'b0; exp_wr = 0; new_v = old_v;
    skip = 1'b0;
    if (op <= 3'd2) begin
      exp_lat = 3;
      exp_rdata = old_v;
      if (op == 3'd0) new_v = src;
      else if (op == 3'd1) new_v = old_v | src;
      else new_v = old_v & ~src;
      skip = (op != 3'd0) && (src == 64'd0);
      exp_wr = skip ? 0 : 1;
      if (skip) new_v = old_v;
    end else if (op == 3'd3) begin
      exp_lat = 2; exp_redir = 1'b1;
      exp_pc = csr_mem[12'h305] & ~64'd3;
    end else if (op == 3'd4) begin
      exp_lat = 2; exp_redir = 1'b1;
      exp_pc = csr_mem[12'h341];
    end else begin
      exp_lat = 1;
    end
    wr0 = wr_count;
    wait_rsp(1'b1, lat);
    $display("op=%0d addr=%03h src=%016h lat=%0d rdata=%016h redir=%0d pc=%016h",
             op, addr, src, lat, bus.rsp_rdata, bus.redir_valid, bus.redir_pc);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
    chk("redir_valid", 64'(bus.redir_valid), 64'(exp_redir));
    chk("redir_pc", bus.redir_pc, exp_pc);
    chk("wr_count", 64'(wr_count - wr0), 64'(exp_wr));
    if (op <= 3'd2) chk("csr_value", csr_mem[addr], new_v);
    if (op == 3'd3) begin
      chk("mepc", csr_mem[12'h341], pc);
      chk("mcause", csr_mem[12'h342], ECALL_CS);
    end
  endtask

  logic [11:0] addr_tab [0:4];
  int lat;
  int wr0;

  initial begin
    for (int i = 0; i < 4096; i++) csr_mem[i] = 64'd0;
    csr_mem[12'h300] = 64'h1888;
    addr_tab[0] = 12'h300; addr_tab[1] = 12'h305; addr_tab[2] = 12'h340;
    addr_tab[3] = 12'h341; addr_tab[4] = 12'h342;
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = 12'd0;
    bus.req_src = 64'd0; bus.req_pc = 64'd0; bus.irq_timer = 1'b0; bus.irq_mie = 1'b0;

    #1;
    chk("rst_ctl", 64'(bus.csr_ctl), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_wdata", bus.csr_wdata, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op(3'd0, 12'h305, 64'h8000_0100, 64'h0);
    chk("rw_ctl_rd", 64'(tr_ctl[1]), 64'b0100);
    chk("rw_ctl_wr", 64'(tr_ctl[2]), 64'b1000);
    chk("rw_wdata", tr_wdata[2], 64'h8000_0100);
    run_op(3'd1, 12'h305, 64'h0, 64'h0);
    chk("rs0_ctl_wr", 64'(tr_ctl[2]), 64'b0000);
    run_op(3'd2, 12'h300, 64'h8, 64'h0);
    chk("rc_wdata", tr_wdata[2], 64'h1880);

    run_op(3'd0, 12'h305, 64'h8000_0103, 64'h0);
    run_op(3'd3, 12'h0, 64'h0, 64'h8000_0040);
    chk("ecall_ctl", 64'(tr_ctl[1]), 64'b0010);
    chk("ecall_wdata", tr_wdata[1], 64'h8000_0040);
    chk("ecall_mcause", tr_mcause[1], ECALL_CS);
    run_op(3'd0, 12'h341, 64'h8000_0044, 64'h0);
    run_op(3'd4, 12'h0, 64'h0, 64'h0);
    chk("mret_ctl", 64'(tr_ctl[1]), 64'b0001);
    run_op(3'd6, 12'h305, 64'h55, 64'h0);

    // Timer interrupt races an ECALL: the interrupt goes first.
    @(negedge clk);
    bus.irq_timer = 1'b1; bus.irq_mie = 1'b1;
    bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.req_pc = 64'h8000_0200;
    #1;
    chk("irq_req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    bus.irq_mie = 1'b0;
    wait_rsp(1'b0, lat);
    $display("irq lat=%0d redir=%0d pc=%016h", lat, bus.redir_valid, bus.redir_pc);
    chk("irq_lat", 64'(lat), 64'd2);
    chk("irq_ctl", 64'(tr_ctl[1]), 64'b0010);
    chk("irq_mcause", tr_mcause[1], TIMER_CS);
    chk("irq_wdata", tr_wdata[1], 64'h8000_0200);
    chk("irq_redir", 64'(bus.redir_valid), 64'd1);
    chk("irq_redir_pc", bus.redir_pc, 64'h8000_0100);
    @(negedge clk); #1;
    chk("after_irq_ready", 64'(bus.req_ready), 64'd1);
    chk("after_irq_busy", 64'(bus.busy), 64'd0);
    chk("irq_mcause_csr", csr_mem[12'h342], TIMER_CS);
    wait_rsp(1'b1, lat);
    $display("pending ecall lat=%0d pc=%016h", lat, bus.redir_pc);
    chk("pend_ecall_lat", 64'(lat), 64'd2);
    chk("pend_ecall_mcause", tr_mcause[1], ECALL_CS);
    chk("pend_ecall_mepc", csr_mem[12'h341], 64'h8000_0200);
    bus.irq_timer = 1'b0;

    // Reset asserted while the CSR read is in flight.
    wr0 = wr_count;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_addr = 12'h340;
    bus.req_src = 64'hdead_beef;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("abort_ctl_rd", 64'(bus.csr_ctl), 64'b0100);
    rst = 1'b0;
    #1;
    chk("abort_ctl", 64'(bus.csr_ctl), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_wdata", bus.csr_wdata, 64'd0);
    chk("abort_req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    chk("abort_no_write", 64'(wr_count - wr0), 64'd0);
    chk("abort_csr", csr_mem[12'h340], 64'd0);
    $display("reset abort done");

    for (int t = 0; t < 200; t++) begin
      logic [63:0] s;
      s = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      run_op(3'($urandom_range(0, 7)), addr_tab[$urandom_range(0, 4)], s,
             {$urandom, $urandom} & ~64'd3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

endmodule
